vram_writer: RTL and testbench

VRAM_WRITER -- requirements
Module: vram_writer

---
 rtl/vram_writer_if.sv | 25 ++
 rtl/vram_writer.sv | 163 ++++++++++++++++
 tb/tb_vram_writer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vram_writer_if.sv
// CPU-side write port of vram_writer: memory/I-O write strobes, address, data
// and the FIFO ready indication returned to the CPU.
interface vram_writer_if;
  logic        cpu_mem_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_io_we;
  logic        cpu_wr_ready;

  modport master (
    output cpu_mem_we,
    output cpu_addr,
    output cpu_data,
    output cpu_io_we,
    input  cpu_wr_ready
  );

  modport slave (
    input  cpu_mem_we,
    input  cpu_addr,
    input  cpu_data,
    input  cpu_io_we,
    output cpu_wr_ready
  );
endinterface

// File: rtl/vram_writer.sv
// Queues CPU screen writes in a 4-entry FIFO and drains them into screen RAM
// outside the video fetch window; also holds the border colour register.
// Optional macro VRAM_WR_OVF_STATUS_EN enables the sticky wr_overflow flag.
module vram_writer (
  input  logic        clk_pix,
  input  logic        reset,
  vram_writer_if.slave cpu,
  input  logic [3:0]  vid_phase,
  input  logic [12:0] vid_address,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic [2:0]  border,
  output logic        wr_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [20:0] fifo_q [0:3];
  logic [20:0] fifo_d [0:3];
  logic [2:0]  border_q, border_d;

  logic        vid_win_s;
  logic        scr_win_s;
  logic        full_s;
  logic        push_s;
  logic        pop_s;
  logic [20:0] head_s;
  logic [20:0] entry_s;

  assign vid_win_s = (vid_phase >= 4'd10) && (vid_phase <= 4'd14);
  assign scr_win_s = (cpu.cpu_addr >= 16'h4000) && (cpu.cpu_addr <= 16'h5AFF);
  assign full_s    = (count_q == 3'd4);
  assign push_s    = cpu.cpu_mem_we && scr_win_s && !full_s && !reset;
  // Inside the window bit 14 is set and bit 13 clear, so the low 13 bits are addr-0x4000.
  assign entry_s   = {cpu.cpu_addr[12:0], cpu.cpu_data};
  assign head_s    = fifo_q[rd_ptr_q];

  assign cpu.cpu_wr_ready = !reset && (count_q < 3'd4);
  assign border           = border_q;

  // FSM decode: drain one entry per clock unless video owns the RAM port.
  always_comb begin
    state_d   = state_q;
    pop_s     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = vid_address;
    ram_wdata = head_s[7:0];
    case (state_q)
      ST_IDLE: begin
        ram_addr = vid_address;
      end
      ST_DRAIN, ST_HOLD: begin
        if (vid_win_s) begin
          ram_addr = vid_address;
        end else begin
          pop_s    = !reset;
          ram_we   = !reset;
          ram_addr = head_s[20:8];
        end
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // Phase may jump arbitrarily, so the state only records emptiness and the last window view.
    if (count_d == 3'd0) begin
      state_d = ST_IDLE;
    end else if (vid_win_s) begin
      state_d = ST_HOLD;
    end else begin
      state_d = ST_DRAIN;
    end
  end

  // FIFO storage, pointers and border register next values.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    border_d = border_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = entry_s;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (cpu.cpu_io_we && !cpu.cpu_addr[0]) begin
      border_d = cpu.cpu_data[2:0];
    end else begin
      border_d = border_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= 3'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      border_q <= 3'd0;
      fifo_q   <= '{default: 21'd0};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      border_q <= border_d;
      fifo_q   <= fifo_d;
    end
  end

`ifdef VRAM_WR_OVF_STATUS_EN
  logic ovf_set_s;
  logic wr_overflow_q, wr_overflow_d;

  assign ovf_set_s = cpu.cpu_mem_we && scr_win_s && full_s;

  // Sticky drop flag, cleared only by reset.
  always_comb begin
    if (ovf_set_s) begin
      wr_overflow_d = 1'b1;
    end else begin
      wr_overflow_d = wr_overflow_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      wr_overflow_q <= 1'b0;
    end else begin
      wr_overflow_q <= wr_overflow_d;
    end
  end

  assign wr_overflow = wr_overflow_q;
`else
  assign wr_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_vram_writer.sv
// Directed self-checking bench for vram_writer; inputs change on the falling
// edge and outputs are checked 1 time unit later.
module tb_vram_writer;

`ifdef VRAM_WR_OVF_STATUS_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif
  localparam logic [12:0] VID_A = 13'h1234;

  logic        clk_pix;
  logic        reset;
  logic [3:0]  vid_phase;
  logic [12:0] vid_address;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [2:0]  border;
  logic        wr_overflow;

  int checks;
  int errors;

  vram_writer_if bus ();

  vram_writer dut (
    .clk_pix     (clk_pix),
    .reset       (reset),
    .cpu         (bus.slave),
    .vid_phase   (vid_phase),
    .vid_address (vid_address),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .border      (border),
    .wr_overflow (wr_overflow)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a new cycle at the falling edge with strobes cleared.
  task automatic cyc(input logic [3:0] ph);
    @(negedge clk_pix);
    vid_phase      = ph;
    bus.cpu_mem_we = 1'b0;
    bus.cpu_io_we  = 1'b0;
  endtask

  task automatic memw(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_mem_we = 1'b1;
    bus.cpu_addr   = a;
    bus.cpu_data   = d;
  endtask

  task automatic iow(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_io_we = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_data  = d;
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, "_we"}, {31'd0, ram_we}, 32'd0);
    chk({tag, "_addr"}, {19'd0, ram_addr}, {19'd0, VID_A});
  endtask

  task automatic wr_chk(input string tag, input logic [12:0] a, input logic [7:0] d);
    #1;
    chk({tag, "_we"}, {31'd0, ram_we}, 32'd1);
    chk({tag, "_addr"}, {19'd0, ram_addr}, {19'd0, a});
    chk({tag, "_data"}, {24'd0, ram_wdata}, {24'd0, d});
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    vid_phase      = 4'd0;
    vid_address    = VID_A;
    bus.cpu_mem_we = 1'b0;
    bus.cpu_io_we  = 1'b0;
    bus.cpu_addr   = 16'h0000;
    bus.cpu_data   = 8'h00;

    // Reset state
    cyc(4'd0); #1;
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ready", {31'd0, bus.cpu_wr_ready}, 32'd0);
    cyc(4'd1); #1;
    chk("rst_border", {29'd0, border}, 32'd0);
    chk("rst_ovf", {31'd0, wr_overflow}, 32'd0);
    cyc(4'd2); reset = 1'b0; #1;
    chk("post_rst_ready", {31'd0, bus.cpu_wr_ready}, 32'd1);
    idle_chk("post_rst");

    // Writes just outside the screen window are ignored
    cyc(4'd3); memw(16'h3FFF, 8'h11);
    cyc(4'd4); memw(16'h5B00, 8'h22); idle_chk("below_win");
    cyc(4'd5); idle_chk("above_win");
    chk("outwin_ready", {31'd0, bus.cpu_wr_ready}, 32'd1);
    chk("outwin_ovf", {31'd0, wr_overflow}, 32'd0);
    cyc(4'd6); idle_chk("outwin_late");

    // Push at phase 3 written at phase 4
    cyc(4'd3); memw(16'h4000, 8'hAA); idle_chk("p3_push");
    cyc(4'd4); wr_chk("p4_write", 13'h0000, 8'hAA);
    cyc(4'd5); idle_chk("p5_empty");

    // Push at phase 9 held across the video window, written at phase 15
    cyc(4'd9); memw(16'h5AFF, 8'h55); idle_chk("p9_push");
    for (int p = 10; p <= 14; p++) begin
      cyc(p[3:0]); idle_chk("hold_win");
    end
    cyc(4'd15); wr_chk("p15_write", 13'h1AFF, 8'h55);
    cyc(4'd0); idle_chk("p0_empty");

    // Border port: even addresses load, odd ignored, high address bits ignored
    cyc(4'd1); iow(16'h00FE, 8'h05);
    cyc(4'd2); iow(16'h00FF, 8'h02); #1;
    chk("border_fe", {29'd0, border}, 32'd5);
    cyc(4'd3); #1;
    chk("border_ff", {29'd0, border}, 32'd5);
    iow(16'hFFFE, 8'hFB);
    cyc(4'd4); #1;
    chk("border_hi", {29'd0, border}, 32'd3);

    // Back-to-back pushes from phase 10: four queued, fifth dropped, sixth dropped during a pop
    for (int i = 0; i < 5; i++) begin
      cyc(4'(10 + i)); memw(16'h4100 + 16'(i), 8'h10 + 8'(i)); idle_chk("burst_push");
    end
    #1;
    chk("full_ready", {31'd0, bus.cpu_wr_ready}, 32'd0);
    cyc(4'd15); memw(16'h4105, 8'h15); wr_chk("burst_w0", 13'h0100, 8'h10);
    chk("ovf", {31'd0, wr_overflow}, {31'd0, OVF_EXP});
    cyc(4'd0); wr_chk("burst_w1", 13'h0101, 8'h11);
    cyc(4'd1); wr_chk("burst_w2", 13'h0102, 8'h12);
    cyc(4'd2); wr_chk("burst_w3", 13'h0103, 8'h13);
    cyc(4'd3); idle_chk("burst_done");
    chk("burst_ready", {31'd0, bus.cpu_wr_ready}, 32'd1);

    // Reset with three entries queued discards them
    cyc(4'd10); memw(16'h4200, 8'hC0);
    cyc(4'd11); memw(16'h4201, 8'hC1);
    cyc(4'd12); memw(16'h4202, 8'hC2);
    cyc(4'd5); reset = 1'b1; #1;
    chk("mid_rst_we", {31'd0, ram_we}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.cpu_wr_ready}, 32'd0);
    cyc(4'd6); reset = 1'b0; idle_chk("after_rst");
    chk("after_rst_ready", {31'd0, bus.cpu_wr_ready}, 32'd1);
    chk("after_rst_border", {29'd0, border}, 32'd0);
    chk("after_rst_ovf", {31'd0, wr_overflow}, 32'd0);
    cyc(4'd7); idle_chk("after_rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
